// File: rtl/test_master_slave_writer_pkg.sv
// Shared types for the master-side test writer: section encoding and value width.
package testmasterslavewriter_types;

    // Width of the integer value carried on the master port.
    localparam int VALUE_W = 32;

    // Writer sections: waiting for a request, emitting one strobe, pacing gap.
    typedef enum logic [1:0] {
        section_idle,
        section_write,
        section_gap
    } TestMasterSlaveWriter_SECTIONS;

endpackage

// File: rtl/test_master_slave_writer.sv
// Master-side writer: posts a stepped, wrapping value with a one-cycle sync
// strobe, then waits GAP_CYCLES before it can write again.
// Optional feature: define WRITER_WRCNT_EN to add a saturating wr_count output.
module test_master_slave_writer
    import testmasterslavewriter_types::*;
#(
    parameter int STEP       = 1,
    parameter int LIMIT      = 100,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [VALUE_W-1:0] m_out,
    output logic               m_out_sync,
    output logic               busy
`ifdef WRITER_WRCNT_EN
    ,
    output logic [15:0]        wr_count
`endif
);

    // Wide enough to hold GAP_CYCLES, since the counter steps once more on the last gap cycle.
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    TestMasterSlaveWriter_SECTIONS section_q, section_d;
    logic [VALUE_W-1:0]            val_q, val_d;
    logic [GAP_W-1:0]              gap_cnt_q, gap_cnt_d;
    logic [VALUE_W-1:0]            m_out_q, m_out_d;
    logic                          sync_q, sync_d;
    logic                          busy_q, busy_d;
    logic signed [VALUE_W:0]       next_sum;
`ifdef WRITER_WRCNT_EN
    logic [15:0]                   wr_count_q, wr_count_d;
`endif

    // State and output registers; asynchronous reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section_q  <= section_idle;
            val_q      <= '0;
            gap_cnt_q  <= '0;
            m_out_q    <= '0;
            sync_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef WRITER_WRCNT_EN
            wr_count_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            section_q  <= section_d;
            val_q      <= val_d;
            gap_cnt_q  <= gap_cnt_d;
            m_out_q    <= m_out_d;
            sync_q     <= sync_d;
            busy_q     <= busy_d;
`ifdef WRITER_WRCNT_EN
            wr_count_q <= wr_count_d;
`endif
        end
    end

    // Next-state logic: section sequencing, wrap adder and gap counter.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        section_d = section_q;
        val_d     = val_q;
        gap_cnt_d = gap_cnt_q;
        m_out_d   = m_out_q;
        sync_d    = 1'b0;
        // One bit wider than the value, so adding STEP can never overflow.
        next_sum  = $signed({1'b0, val_q}) + (VALUE_W + 1)'(STEP);

        case (section_q)
            section_idle: begin
                if (start) begin
                    section_d = section_write;
                end
            end
            section_write: begin
                m_out_d   = val_q;
                sync_d    = 1'b1;
                gap_cnt_d = '0;
                val_d     = (next_sum <= (VALUE_W + 1)'(LIMIT)) ? next_sum[VALUE_W-1:0] : '0;
                section_d = section_gap;
            end
            section_gap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                // start only matters on the final gap cycle.
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    section_d = start ? section_write : section_idle;
                end
            end
            default: begin
                section_d = section_idle;
            end
        endcase

        // busy is registered from the next section so it tracks section_q exactly.
        busy_d = (section_d != section_idle);
    end

`ifdef WRITER_WRCNT_EN
    // Count every strobe, holding at the top value instead of wrapping.
    always_comb begin
        wr_count_d = wr_count_q;
        if (sync_d && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    assign wr_count = wr_count_q;
`endif

    assign m_out      = m_out_q;
    assign m_out_sync = sync_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_test_master_slave_writer.sv
// Self-checking bench for test_master_slave_writer: three instances with
// different STEP/LIMIT share one stimulus; an interval-based model predicts them.
module tb_test_master_slave_writer;

    localparam int GAP  = 2;
    localparam int NDUT = 3;

    int step_of  [NDUT] = '{1, 30, 7};
    int limit_of [NDUT] = '{100, 100, 5};

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mo [NDUT];
    logic        ms [NDUT];
    logic        bz [NDUT];
`ifdef WRITER_WRCNT_EN
    logic [15:0] wc [NDUT];
`endif

    test_master_slave_writer #(.STEP(1), .LIMIT(100), .GAP_CYCLES(GAP)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .m_out(mo[0]), .m_out_sync(ms[0]), .busy(bz[0])
`ifdef WRITER_WRCNT_EN
        , .wr_count(wc[0])
`endif
    );

    test_master_slave_writer #(.STEP(30), .LIMIT(100), .GAP_CYCLES(GAP)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .m_out(mo[1]), .m_out_sync(ms[1]), .busy(bz[1])
`ifdef WRITER_WRCNT_EN
        , .wr_count(wc[1])
`endif
    );

    test_master_slave_writer #(.STEP(7), .LIMIT(5), .GAP_CYCLES(GAP)) dut_c (
        .clk(clk), .rst(rst), .start(start),
        .m_out(mo[2]), .m_out_sync(ms[2]), .busy(bz[2])
`ifdef WRITER_WRCNT_EN
        , .wr_count(wc[2])
`endif
    );

    always #5 clk = ~clk;

    // Reference model: writer is free again GAP+1 edges after accepting a request.
    int          edge_n;
    int          ready_e;
    int          strobe_e;
    logic [31:0] cur     [NDUT];
    logic [31:0] out_exp [NDUT];
    int          cnt_exp [NDUT];
    logic        sync_exp;
    logic        busy_exp;
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] next_val(input logic [31:0] v, input int s, input int l);
        longint sum;
        sum = longint'(v) + longint'(s);
        return (sum > longint'(l)) ? 32'd0 : 32'(sum);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            cur[k]     = '0;
            out_exp[k] = '0;
            cnt_exp[k] = 0;
        end
        strobe_e = -1;
        ready_e  = 0;
    endtask

    // One clock: drive start, update the model for this edge, compare #1 later.
    task automatic step(input logic s);
        start = s;
        @(posedge clk);
        edge_n++;
        sync_exp = (strobe_e == edge_n);
        if (sync_exp) begin
            for (int k = 0; k < NDUT; k++) begin
                out_exp[k] = cur[k];
                cur[k]     = next_val(cur[k], step_of[k], limit_of[k]);
                if (cnt_exp[k] < 16'hFFFF) cnt_exp[k]++;
            end
        end
        if (s && edge_n >= ready_e) begin
            strobe_e = edge_n + 1;
            ready_e  = edge_n + GAP + 1;
        end
        busy_exp = (edge_n < ready_e);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("m_out", mo[k], out_exp[k]);
            check("m_out_sync", 32'(ms[k]), 32'(sync_exp));
            check("busy", 32'(bz[k]), 32'(busy_exp));
`ifdef WRITER_WRCNT_EN
            check("wr_count", 32'(wc[k]), 32'(cnt_exp[k]));
`endif
        end
        if (ms[0]) q_a.push_back(mo[0]);
        if (ms[1]) q_b.push_back(mo[1]);
    endtask

    // Assert reset mid-cycle; outputs must clear before any clock edge arrives.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("async_m_out", mo[k], 32'd0);
            check("async_sync", 32'(ms[k]), 32'd0);
            check("async_busy", 32'(bz[k]), 32'd0);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int          bc;
        int          sc;
        int          guard;
        logic [31:0] wrap_exp [6];

        wrap_exp = '{32'd0, 32'd30, 32'd60, 32'd90, 32'd0, 32'd30};
        edge_n = 0;
        model_reset();

        // Power-on reset: two edges with rst high, values checked while held.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_m_out", mo[k], 32'd0);
            check("rst_sync", 32'(ms[k]), 32'd0);
            check("rst_busy", 32'(bz[k]), 32'd0);
        end
        rst = 1'b0;

        // Idle with start low: no strobes.
        repeat (5) step(1'b0);

        // Single request: one strobe carrying 0, busy for write + gap cycles.
        bc = 0;
        sc = 0;
        step(1'b1);
        bc += int'(bz[0]);
        repeat (6) begin
            step(1'b0);
            bc += int'(bz[0]);
            sc += int'(ms[0]);
        end
        check("single_busy_len", 32'(bc), 32'(GAP + 1));
        check("single_strobes", 32'(sc), 32'd1);

        // Second pulse carries the next value.
        step(1'b1);
        repeat (6) step(1'b0);
        check("second_value", mo[0], 32'd1);

        // Held start from a fresh sequence: six strobes, then reset in the
        // first gap cycle after m_out=5.
        async_reset();
        q_a.delete();
        q_b.delete();
        guard = 0;
        while (!(ms[0] === 1'b1 && mo[0] === 32'd5) && guard < 40) begin
            step(1'b1);
            guard++;
        end
        check("held_reached_5", 32'(guard < 40), 32'd1);
        check("held_count", 32'(q_a.size()), 32'd6);
        for (int i = 0; i < 6 && i < q_a.size(); i++) check("held_seq", q_a[i], 32'(i));
        for (int i = 0; i < 6 && i < q_b.size(); i++) check("wrap_seq", q_b[i], wrap_exp[i]);
        check("held_span", 32'(guard), 32'(5 * (GAP + 1) + 2));

        async_reset();
        q_a.delete();
        step(1'b1);
        repeat (4) step(1'b0);
        check("after_reset_value", 32'(q_a.size()), 32'd1);
        if (q_a.size() > 0) check("after_reset_m_out", q_a[0], 32'd0);

        // Randomized requests with one reset dropped in the middle.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) async_reset();
            step(1'($urandom_range(0, 1)));
        end
        repeat (4) step(1'b0);

`ifdef WRITER_WRCNT_EN
        // Counter: five writes, then saturation at the top value.
        async_reset();
        repeat (5) begin
            step(1'b1);
            repeat (3) step(1'b0);
        end
        check("wr_count_5", 32'(wc[0]), 32'd5);
        force dut_a.wr_count_q = 16'hFFFF;
        #1;
        release dut_a.wr_count_q;
        cnt_exp[0] = 16'hFFFF;
        step(1'b1);
        repeat (3) step(1'b0);
        check("wr_count_sat", 32'(wc[0]), 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
